// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: FSM states,
// the blank pattern and the active-low hex decode table.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for nibble n.
    localparam logic [15:0][6:0] HEX_SEG_TBL = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_scanner_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
import seg7_pkg::*;

module hex_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TBL[nibble];

endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed 7-segment driver: synchronises the divided clock into scan
// ticks and walks the digits with a blanking gap between them.
import seg7_pkg::*;

module seg7_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 2,
    parameter int IDX_W        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Dclk,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("seg7_scanner: NUM_DIGITS must be 2..8");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_blank
        $error("seg7_scanner: BLANK_CYCLES must be 1..255");
    end
    if (IDX_W != $clog2(NUM_DIGITS)) begin : g_bad_idx
        $error("seg7_scanner: IDX_W must equal clog2(NUM_DIGITS)");
    end

    logic                  s1_q, s2_q, s3_q;
    logic                  tick;
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_n_q, dp_n_d;
    logic                  show_d;
    logic [3:0]            nibble;
    logic [6:0]            dec_seg;

    // Dclk is only ever sampled; s2/s3 are the settled pair used for edges.
    assign tick = s2_q & ~s3_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!en) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d = ST_BLANK;
                    cnt_d   = BLANK_LOAD;
                end
                ST_BLANK: begin
                    if (cnt_q == '0) state_d = ST_SHOW;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_SHOW: begin
                    if (tick) begin
                        state_d = ST_BLANK;
                        cnt_d   = BLANK_LOAD;
                        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Outputs are decoded from the next state so an and seg flip together.
    assign show_d = (state_d == ST_SHOW);
    assign nibble = value[{idx_d, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        seg_d  = show_d ? dec_seg : SEG_BLANK;
        dp_n_d = show_d ? ~dp[idx_d] : 1'b1;
        an_d   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (show_d && idx_d == IDX_W'(i)) an_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= ST_OFF;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_n_q  <= 1'b1;
        end else begin
            s1_q    <= Dclk;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_n_q  <= dp_n_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp_n      = dp_n_q;
    assign digit_idx = idx_q;

endmodule
